syzygy_frame_align: RTL and testbench

Frame-clock alignment controller for the SYZYGY ADC deserialiser path, in the ADC divided-clock domain. Watches the deserialised frame-clock word from the ISERDES and issues single-cycle bitslip pulses until the word matches the expected frame pattern. Produces `bitslip_count` and `clk_align_frame_valid`, which feed the AXI-Lite status register block (register 1). Takes `enable_adc` and `mmcm_locked` as its run qualifiers.

---
 rtl/syzygy_frame_align.sv | 172 +++++++++++++++++
 tb/tb_syzygy_frame_align.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syzygy_frame_align.sv
// Frame-clock alignment for the SYZYGY ADC deserialiser: slips the ISERDES until
// the frame word matches FRAME_PATTERN, then watches for loss of lock.
//   state  | meaning
//   IDLE   | run low, nothing in progress
//   SETTLE | waiting for the ISERDES output to settle
//   CHECK  | counting consecutive pattern matches
//   SLIP   | single-cycle bitslip pulse
//   LOCKED | aligned, watching for a mismatch
//   FAIL   | gave up after MAX_SLIPS slips
module syzygy_frame_align #(
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] FRAME_PATTERN = DATA_WIDTH'(8'hF0),
  parameter int                    SETTLE_CYCLES = 16,
  parameter int                    MATCH_COUNT   = 64,
  parameter int                    MAX_SLIPS     = 16
) (
  input  logic                  adc_clock,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  mmcm_locked,
  input  logic [DATA_WIDTH-1:0] frame_data,
  output logic                  bitslip,
  output logic [3:0]            bitslip_count,
  output logic                  clk_align_frame_valid,
  output logic                  align_error,
  output logic [7:0]            lock_loss_count
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int MATCH_W  = (MATCH_COUNT > 1) ? $clog2(MATCH_COUNT) : 1;
  localparam int ATT_W    = $clog2(MAX_SLIPS + 1);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(MATCH_COUNT - 1);
  localparam logic [ATT_W-1:0]    ATT_MAX     = ATT_W'(MAX_SLIPS);
  localparam logic [3:0]          SLIP_WRAP   = 4'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    SLIP,
    LOCKED,
    FAIL
  } state_t;

  state_t              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [ATT_W-1:0]    att_q, att_d;
  logic                bitslip_q, bitslip_d;
  logic [3:0]          slip_cnt_q, slip_cnt_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [7:0]          llc_q, llc_d;

  logic       run;
  logic       match;
  logic [3:0] slip_cnt_next;

  assign run           = enable & mmcm_locked;
  assign match         = (frame_data == FRAME_PATTERN);
  assign slip_cnt_next = (slip_cnt_q == SLIP_WRAP) ? 4'd0 : slip_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    match_d    = match_q;
    att_d      = att_q;
    bitslip_d  = 1'b0;
    slip_cnt_d = slip_cnt_q;
    valid_d    = valid_q;
    err_d      = err_q;
    llc_d      = llc_q;

    if (!run) begin
      state_d = IDLE;
      valid_d = 1'b0;
      err_d   = 1'b0;
      att_d   = '0;
      // The pulse already on the wire still moves the ISERDES, so count it.
      if (state_q == SLIP) begin
        slip_cnt_d = slip_cnt_next;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = SETTLE;
          settle_d = SETTLE_LOAD;
        end
        SETTLE: begin
          if (settle_q == '0) begin
            state_d = CHECK;
            match_d = '0;
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end
        CHECK: begin
          if (match) begin
            if (match_q == MATCH_LAST) begin
              state_d = LOCKED;
              valid_d = 1'b1;
              att_d   = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else if (att_q == ATT_MAX) begin
            state_d = FAIL;
            err_d   = 1'b1;
          end else begin
            state_d   = SLIP;
            bitslip_d = 1'b1;
          end
        end
        SLIP: begin
          slip_cnt_d = slip_cnt_next;
          att_d      = att_q + 1'b1;
          state_d    = SETTLE;
          settle_d   = SETTLE_LOAD;
        end
        LOCKED: begin
          if (!match) begin
            state_d = CHECK;
            valid_d = 1'b0;
            match_d = '0;
            if (llc_q != 8'hFF) begin
              llc_d = llc_q + 8'd1;
            end
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge adc_clock) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      match_q    <= '0;
      att_q      <= '0;
      bitslip_q  <= 1'b0;
      slip_cnt_q <= 4'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      llc_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      match_q    <= match_d;
      att_q      <= att_d;
      bitslip_q  <= bitslip_d;
      slip_cnt_q <= slip_cnt_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      llc_q      <= llc_d;
    end
  end

  assign bitslip               = bitslip_q;
  assign bitslip_count         = slip_cnt_q;
  assign clk_align_frame_valid = valid_q;
  assign align_error           = err_q;
  assign lock_loss_count       = llc_q;

endmodule

// File: tb/tb_syzygy_frame_align.sv
// Bench for syzygy_frame_align: a timeline model of the alignment procedure
// checked every cycle, plus directed scenarios with hand-computed timings.
module tb_syzygy_frame_align;

  localparam int         S   = 16;
  localparam int         M   = 64;
  localparam int         MX  = 16;
  localparam logic [7:0] PAT = 8'hF0;

  logic       adc_clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       mmcm_locked = 1'b0;
  logic [7:0] frame_data;
  logic       bitslip;
  logic [3:0] bitslip_count;
  logic       clk_align_frame_valid;
  logic       align_error;
  logic [7:0] lock_loss_count;

  syzygy_frame_align #(
    .DATA_WIDTH(8), .FRAME_PATTERN(PAT), .SETTLE_CYCLES(S),
    .MATCH_COUNT(M), .MAX_SLIPS(MX)
  ) dut (
    .adc_clock(adc_clock), .rst_n(rst_n), .enable(enable),
    .mmcm_locked(mmcm_locked), .frame_data(frame_data), .bitslip(bitslip),
    .bitslip_count(bitslip_count), .clk_align_frame_valid(clk_align_frame_valid),
    .align_error(align_error), .lock_loss_count(lock_loss_count)
  );

  always #5 adc_clock = ~adc_clock;

  int cyc = 0;
  always @(posedge adc_clock) cyc <= cyc + 1;

  // ISERDES stand-in: in rotate mode the word walks one bit back toward the
  // pattern for every bitslip pulse seen.
  int         pulses = 0;
  int         last_rise = -1;
  int         min_gap = 100000;
  bit         rot_mode = 1'b0;
  int         rot_base = 0;
  logic [7:0] fd_const = PAT;

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  assign frame_data = rot_mode ? rotl(PAT, (rot_base - pulses) & 7) : fd_const;

  always @(negedge adc_clock) begin
    if (bitslip) begin
      if (last_rise >= 0 && (cyc - last_rise) < min_gap) min_gap <= cyc - last_rise;
      last_rise <= cyc;
      pulses    <= pulses + 1;
    end
  end

  // Behavioural model: the alignment procedure as a timeline of edges.
  bit m_bs = 1'b0, m_valid = 1'b0, m_err = 1'b0;
  int m_count = 0, m_llc = 0;

  task automatic tick(output int ab);
    @(posedge adc_clock);
    if (!rst_n) begin
      m_bs = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_count = 0; m_llc = 0; ab = 2;
    end else if (!(enable && mmcm_locked)) begin
      m_bs = 1'b0; m_valid = 1'b0; m_err = 1'b0; ab = 1;
    end else begin
      ab = 0;
    end
  endtask

  task automatic run_align();
    int ab, slips, streak;
    bit need_settle;
    slips = 0;
    need_settle = 1'b1;
    forever begin
      if (need_settle) begin
        for (int i = 0; i < S; i++) begin
          tick(ab);
          if (ab != 0) return;
        end
      end
      need_settle = 1'b1;
      streak = 0;
      while (streak < M) begin
        tick(ab);
        if (ab != 0) return;
        if (frame_data == PAT) streak++;
        else break;
      end
      if (streak < M) begin
        if (slips == MX) begin
          m_err = 1'b1;
          forever begin
            tick(ab);
            if (ab != 0) return;
          end
        end
        m_bs = 1'b1;
        tick(ab);
        if (ab != 2) m_count = (m_count + 1) % 8;
        m_bs = 1'b0;
        if (ab != 0) return;
        slips++;
      end else begin
        m_valid = 1'b1;
        slips = 0;
        do begin
          tick(ab);
          if (ab != 0) return;
        end while (frame_data == PAT);
        m_valid = 1'b0;
        if (m_llc < 255) m_llc++;
        need_settle = 1'b0;
      end
    end
  endtask

  initial begin : model
    int ab;
    forever begin
      tick(ab);
      if (ab == 0) run_align();
    end
  end

  int n_vec = 0, n_err = 0;
  bit checking = 1'b0;
  bit prev_bs = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge adc_clock);
  endtask

  // sel: 0 valid, 1 align_error, 2 bitslip; at = cycle index of the rising edge
  task automatic wait_for(input int sel, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge adc_clock);
      if ((sel == 0 && clk_align_frame_valid) || (sel == 1 && align_error) ||
          (sel == 2 && bitslip)) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin : stim
    int e0, at, p0, l_edge;
    fork
      forever begin
        @(negedge adc_clock);
        if (checking) begin
          check("bitslip", int'(bitslip), int'(m_bs));
          check("bitslip_count", int'(bitslip_count), m_count);
          check("valid", int'(clk_align_frame_valid), int'(m_valid));
          check("align_error", int'(align_error), int'(m_err));
          check("lock_loss_count", int'(lock_loss_count), m_llc);
          check("valid_and_error", int'(clk_align_frame_valid & align_error), 0);
          check("bitslip_back_to_back", int'(bitslip & prev_bs), 0);
          prev_bs = bitslip;
        end
      end
    join_none

    step(3);
    check("reset_bitslip", int'(bitslip), 0);
    check("reset_count", int'(bitslip_count), 0);
    check("reset_valid", int'(clk_align_frame_valid), 0);
    check("reset_error", int'(align_error), 0);
    check("reset_llc", int'(lock_loss_count), 0);
    rst_n = 1'b1;
    checking = 1'b1;

    // Aligned input
    mmcm_locked = 1'b1;
    enable = 1'b1;
    e0 = cyc + 1;
    p0 = pulses;
    wait_for(0, 300, at);
    check("aligned_valid_latency", at - e0, 80);
    check("aligned_pulses", pulses - p0, 0);
    check("aligned_count", int'(bitslip_count), 0);

    // Rotated by 3
    enable = 1'b0;
    step(2);
    check("disable_valid", int'(clk_align_frame_valid), 0);
    rot_base = pulses + 3;
    rot_mode = 1'b1;
    p0 = pulses;
    enable = 1'b1;
    e0 = cyc + 1;
    wait_for(0, 1000, at);
    check("rot_valid_latency", at - e0, 134);
    check("rot_pulses", pulses - p0, 3);
    check("rot_count", int'(bitslip_count), 3);
    check("rot_error", int'(align_error), 0);

    // Never matches
    rot_mode = 1'b0;
    fd_const = 8'h00;
    rst_n = 1'b0;
    step(1);
    check("rst_count", int'(bitslip_count), 0);
    rst_n = 1'b1;
    e0 = cyc + 1;
    p0 = pulses;
    wait_for(1, 800, at);
    check("fail_latency", at - e0, 305);
    check("fail_pulses", pulses - p0, 16);
    check("fail_count", int'(bitslip_count), 0);
    step(30);
    check("fail_no_more_pulses", pulses - p0, 16);
    enable = 1'b0;
    step(1);
    check("fail_cleared", int'(align_error), 0);

    // Glitch while locked
    fd_const = PAT;
    enable = 1'b1;
    e0 = cyc + 1;
    wait_for(0, 300, at);
    check("relock_latency", at - e0, 80);
    p0 = pulses;
    fd_const = 8'hF1;
    l_edge = cyc + 1;
    step(1);
    fd_const = PAT;
    check("glitch_valid", int'(clk_align_frame_valid), 0);
    check("glitch_llc", int'(lock_loss_count), 1);
    wait_for(0, 300, at);
    check("glitch_relock", at - l_edge, 64);
    check("glitch_pulses", pulses - p0, 0);

    // mmcm_locked drops mid-SETTLE
    mmcm_locked = 1'b0;
    step(1);
    check("mmcm_drop_valid", int'(clk_align_frame_valid), 0);
    mmcm_locked = 1'b1;
    step(6);
    mmcm_locked = 1'b0;
    step(1);
    check("settle_drop_bitslip", int'(bitslip), 0);
    check("settle_drop_count", int'(bitslip_count), 0);
    mmcm_locked = 1'b1;
    e0 = cyc + 1;
    wait_for(0, 300, at);
    check("settle_restart_latency", at - e0, 80);

    // mmcm_locked drops during the bitslip pulse
    enable = 1'b0;
    step(1);
    rot_base = pulses + 1;
    rot_mode = 1'b1;
    p0 = pulses;
    enable = 1'b1;
    e0 = cyc + 1;
    wait_for(2, 100, at);
    mmcm_locked = 1'b0;
    check("first_pulse_time", at - e0, 17);
    check("pulse_count_before", int'(bitslip_count), 0);
    step(1);
    check("slip_drop_bitslip", int'(bitslip), 0);
    check("slip_drop_count", int'(bitslip_count), 1);
    mmcm_locked = 1'b1;
    e0 = cyc + 1;
    wait_for(0, 300, at);
    check("slip_drop_relock", at - e0, 80);
    check("slip_drop_pulses", pulses - p0, 1);

    // Reset while locked with count 5
    enable = 1'b0;
    step(1);
    rot_base = pulses + 4;
    enable = 1'b1;
    wait_for(0, 1000, at);
    check("count_five", int'(bitslip_count), 5);
    rst_n = 1'b0;
    step(1);
    check("lock_rst_valid", int'(clk_align_frame_valid), 0);
    check("lock_rst_count", int'(bitslip_count), 0);
    check("lock_rst_llc", int'(lock_loss_count), 0);
    rst_n = 1'b1;
    e0 = cyc + 1;
    wait_for(0, 300, at);
    check("post_rst_latency", at - e0, 80);
    check("min_bitslip_gap", min_gap, 18);

    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
